// File: rtl/tilt_dist_sq.sv
// ============================================================================
// Module   : tilt_dist_sq
// Purpose  : Sequential dx^2 + dy^2 shift-add engine feeding the tilt sqrt.
//            Build macro TILT_DIST_RADIX4_EN selects 2 bits/cycle (N = 6).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tilt_dist_sq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [10:0] dx,
   input  logic [10:0] dy,
   output logic        busy,
   output logic        done,
   output logic [21:0] sum_sq
);

`ifdef TILT_DIST_RADIX4_EN
   localparam int c_mw   = 12;
   localparam int c_n    = 6;
   localparam int c_step = 2;
`else
   localparam int c_mw   = 11;
   localparam int c_n    = 11;
   localparam int c_step = 1;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SQ_X   = 2'd1,
      S_SQ_Y   = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [21:0]       r_acc;
   logic [21:0]       r_mcand;
   logic [c_mw-1:0]   r_mplier;
   logic [10:0]       r_mag_y;
   logic [3:0]        r_cnt;
   logic              r_done;
   logic [21:0]       r_sum;
   logic [10:0]       w_mag_x;
   logic [10:0]       w_mag_y;
   logic [21:0]       w_pp;
   logic              w_last;

   // 11-bit wrap of the negation maps -1024 onto magnitude 1024
   assign w_mag_x = dx[10] ? (~dx + 11'd1) : dx;
   assign w_mag_y = dy[10] ? (~dy + 11'd1) : dy;
   assign w_last  = (r_cnt == 4'd1);

`ifdef TILT_DIST_RADIX4_EN
   always_comb begin
      w_pp = 22'd0;
      case (r_mplier[1:0])
         2'd1:    w_pp = r_mcand;
         2'd2:    w_pp = r_mcand << 1;
         2'd3:    w_pp = r_mcand + (r_mcand << 1);
         default: w_pp = 22'd0;
      endcase
   end
`else
   assign w_pp = r_mplier[0] ? r_mcand : 22'd0;
`endif

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      case (r_state)
         S_IDLE:   if (start) w_next = S_SQ_X;
         S_SQ_X: begin
            busy = 1'b1;
            if (w_last) w_next = S_SQ_Y;
         end
         S_SQ_Y: begin
            busy = 1'b1;
            if (w_last) w_next = S_FINISH;
         end
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_acc    <= 22'd0;
         r_mcand  <= 22'd0;
         r_mplier <= '0;
         r_mag_y  <= 11'd0;
         r_cnt    <= 4'd0;
         r_done   <= 1'b0;
         r_sum    <= 22'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_acc    <= 22'd0;
                  r_cnt    <= 4'(c_n);
                  r_mcand  <= 22'(w_mag_x);
                  r_mplier <= c_mw'(w_mag_x);
                  r_mag_y  <= w_mag_y;
               end
            end
            S_SQ_X: begin
               r_acc    <= r_acc + w_pp;
               r_mcand  <= r_mcand << c_step;
               r_mplier <= r_mplier >> c_step;
               r_cnt    <= r_cnt - 4'd1;
               // reload operands for the second square on the final step
               if (w_last) begin
                  r_mcand  <= 22'(r_mag_y);
                  r_mplier <= c_mw'(r_mag_y);
                  r_cnt    <= 4'(c_n);
               end
            end
            S_SQ_Y: begin
               r_acc    <= r_acc + w_pp;
               r_mcand  <= r_mcand << c_step;
               r_mplier <= r_mplier >> c_step;
               r_cnt    <= r_cnt - 4'd1;
            end
            S_FINISH: begin
               r_sum  <= r_acc;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign done   = r_done;
   assign sum_sq = r_sum;

endmodule

`default_nettype wire

// File: doc/tilt_dist_sq.md
# tilt_dist_sq

Sequential sum-of-squares engine that computes dx² + dy² from the tracker's signed target offsets. It produces the 22-bit radicand consumed directly by the tilt square-root stage, so the tilt path receives the planar distance before the angle lookup. It uses an iterative shift-add multiplier instead of DSP multipliers and processes one offset pair per start handshake.

## Interface
Parameters: none; widths are fixed by the downstream 22-bit radicand.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  request; sampled only while idle
- dx  in  11  signed two's-complement x offset, -1024..1023
- dy  in  11  signed two's-complement y offset, -1024..1023
- busy  out  1  high while a computation is in progress
- done  out  1  one-cycle pulse; sum_sq valid and new
- sum_sq  out  22  unsigned dx² + dy²; holds until the next done

## Operation
- FSM states: IDLE, SQ_X, SQ_Y, FINISH.
- IDLE:
  - When start=1, capture |dx| and |dy| as 11-bit unsigned magnitudes. -1024 maps to 1024.
  - Clear the 22-bit accumulator, load the iteration counter with N, and go to SQ_X.
- SQ_X: each cycle, conditionally add the shifted multiplicand into the accumulator from the multiplier LSB(s), then shift. After N iterations, go to SQ_Y.
- SQ_Y: same as SQ_X, applied to |dy|, accumulating on top of dx². After N iterations, go to FINISH.
- FINISH: register the accumulator into sum_sq, pulse done, return to IDLE.
- Arithmetic:
  - Each square is at most 2^20; the sum is at most 2^21 (0x200000).
  - The 22-bit accumulator never overflows; no saturation logic.
- Inputs are captured at the accepting edge. Later changes to dx/dy are ignored until the next accepted start.
- start while busy=1 is ignored. There is no queueing and no error flag.
- reset=0 at any edge, including mid-computation:
  - state returns to IDLE;
  - busy=0, done=0, sum_sq=0, accumulator cleared;
  - the in-flight result is discarded.

## Timing
- Reset values: busy=0, done=0, sum_sq=22'd0.
- N = 11 iterations per square (radix-2, default) or N = 6 (radix-4, see Configuration).
- Edge numbering: E0 is the edge where start is accepted.
  - busy rises after E0.
  - SQ_X occupies edges E1..EN; SQ_Y occupies E(N+1)..E(2N).
  - At E(2N+1): sum_sq updates, done=1 for exactly one cycle, busy=0.
- Latency:
  - default: done visible 23 cycles after the accepting edge;
  - radix-4: 13 cycles.
- busy and done are never both high.
- start asserted during the done cycle is accepted at the next edge, since the FSM is in IDLE. Back-to-back throughput is one result per 2N+2 cycles.
- Downstream samples sum_sq on done. The sqrt stage's own ready indicates its output; this block does not wait on it.

## Configuration
- Macro: TILT_DIST_RADIX4_EN.
- Defined:
  - Magnitudes are zero-extended to 12 bits and 2 multiplier bits are consumed per cycle (partial products 0, 1×, 2×, 3× multiplicand), so N = 6.
  - Latency is 13 cycles.
- Undefined: 1 bit per cycle, N = 11, latency 23 cycles.
- Results are bit-identical in both builds; only done timing differs.

## Test plan
- Reset, then dx=3, dy=4, start pulse:
  - busy high for 22 cycles (12 with TILT_DIST_RADIX4_EN);
  - done pulses on the 23rd edge (13th with the macro) with sum_sq=25.
- dx=-1024, dy=-1024 -> sum_sq=2097152 (0x200000); confirms magnitude and MSB handling.
- dx=1023, dy=-1 -> sum_sq=1046530. Then dx=0, dy=0 -> sum_sq=0, with done still pulsing.
- dx=5, dy=12, start held high for the entire computation:
  - exactly one done with sum_sq=169;
  - next computation accepted on the edge after the done cycle, not before.
- Start dx=100, dy=200. Assert reset=0 at cycle 10 for one cycle:
  - busy=0, done never pulses, sum_sq=0.
  - A new start dx=6, dy=8 then yields 100 with nominal latency.
- Start dx=7, dy=-7. Change dx/dy to 500/500 one cycle later -> sum_sq=98, confirming inputs are captured at E0.
